// File: rtl/key_flash_pkg.sv
// -----------------------------------------------------------------------------
// key_flash_pkg
// Shared definitions for the push-button flasher front end: FSM state
// encoding, default timing constants, timer width and a counter-width helper.
// Optional feature macro used by the design: KEY_FLASH_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package key_flash_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } state_t;

  // 20 ms and 5 s at a 50 MHz system clock
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd1_000_000;
  localparam int unsigned FLASH_CYCLES_DEF    = 32'd250_000_000;

  localparam int unsigned TMR_W = 32'd28;

  // Width needed for a counter that runs 0 .. n-1 (n >= 2).
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchroniser, stability counter and falling-edge press detector
// for a raw active-low push-button.
// Ports:
//   sys_clk   in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   key_in    in   raw key, active-low, asynchronous to sys_clk
//   key_press out  registered one-cycle pulse per debounced press
// Parameter: DEBOUNCE_CYCLES (>= 2) stable cycles to accept a new level.
// -----------------------------------------------------------------------------
module key_debounce
  import key_flash_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_press
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

  logic          key_meta_r;
  logic          key_sync_r;
  logic          key_stable_r;
  logic          key_stable_d_r;
  logic          key_press_r;
  logic [CW-1:0] cnt_r;

  logic [CW-1:0] cnt_nxt_s;
  logic          stable_nxt_s;

  // Debounce next-state: count while the synchronised level differs, accept it on the last count.
  always_comb begin
    cnt_nxt_s    = CNT_ZERO;
    stable_nxt_s = key_stable_r;
    if (key_sync_r != key_stable_r) begin
      if (cnt_r == CNT_LAST) begin
        stable_nxt_s = key_sync_r;
        cnt_nxt_s    = CNT_ZERO;
      end else begin
        cnt_nxt_s    = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = CNT_ZERO;
    end
  end

  // Synchroniser, debounce state and press pulse registers.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      key_meta_r     <= 1'b1;
      key_sync_r     <= 1'b1;
      key_stable_r   <= 1'b1;
      key_stable_d_r <= 1'b1;
      key_press_r    <= 1'b0;
      cnt_r          <= CNT_ZERO;
    end else begin
      key_meta_r     <= key_in;
      key_sync_r     <= key_meta_r;
      key_stable_r   <= stable_nxt_s;
      key_stable_d_r <= key_stable_r;
      // Only the 1->0 (press) edge of the clean level produces a pulse.
      key_press_r    <= key_stable_d_r & ~key_stable_r;
      cnt_r          <= cnt_nxt_s;
    end
  end

  assign key_press = key_press_r;

endmodule

// File: rtl/key_flash_ctrl.sv
// -----------------------------------------------------------------------------
// key_flash_ctrl
// Push-button front end for the LED flasher: debounced key press toggles a
// two-state IDLE/FLASH machine whose state drives the flasher enable.
// With KEY_FLASH_TIMEOUT_EN defined, a 28-bit timer ends FLASH after
// FLASH_CYCLES cycles and pulses flash_done; otherwise flash_done is 0 and
// FLASH_CYCLES is accepted but unused.
// Ports:
//   sys_clk    in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   key_in     in   raw key, active-low, asynchronous
//   valid      out  1 while in FLASH (flasher enable)
//   key_press  out  one-cycle pulse per debounced press
//   flash_done out  one-cycle pulse when the auto-off timer expires
// -----------------------------------------------------------------------------
module key_flash_ctrl
  import key_flash_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned FLASH_CYCLES    = FLASH_CYCLES_DEF
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic key_in,
  output logic valid,
  output logic key_press,
  output logic flash_done
);

  // Reject configurations the counters cannot represent.
  if (DEBOUNCE_CYCLES < 32'd2) begin : g_bad_debounce
    $error("key_flash_ctrl: DEBOUNCE_CYCLES must be at least 2");
  end
  if ((FLASH_CYCLES < 32'd2) || (FLASH_CYCLES > 32'd268_435_456)) begin : g_bad_flash
    $error("key_flash_ctrl: FLASH_CYCLES must be in 2 .. 2**28");
  end

  logic   key_press_s;
  state_t state_r;
  state_t state_nxt_s;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_press(key_press_s)
  );

`ifdef KEY_FLASH_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FLASH_CYCLES - 32'd1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(32'd1);
  localparam logic [TMR_W-1:0] TMR_ZERO = TMR_W'(32'd0);

  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] timer_nxt_s;
  logic             flash_done_r;
  logic             done_nxt_s;

  // FSM next state with timeout; timeout wins over a coincident press and does not re-arm.
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = TMR_ZERO;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (key_press_s) begin
          state_nxt_s = FLASH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FLASH: begin
        if (timer_r == TMR_LAST) begin
          state_nxt_s = IDLE;
          done_nxt_s  = 1'b1;
        end else if (key_press_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FLASH;
          timer_nxt_s = timer_r + TMR_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, timer and done-pulse registers.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      timer_r      <= TMR_ZERO;
      flash_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      timer_r      <= timer_nxt_s;
      flash_done_r <= done_nxt_s;
    end
  end

  assign flash_done = flash_done_r;
`else
  // FSM next state: FLASH is left only by a press.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (key_press_s) begin
          state_nxt_s = FLASH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FLASH: begin
        if (key_press_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FLASH;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign flash_done = 1'b0;
`endif

  // The one-bit state register is the enable itself.
  assign valid     = (state_r == FLASH);
  assign key_press = key_press_s;

endmodule

// File: tb/tb_key_flash_ctrl.sv
// Scoreboard bench for key_flash_ctrl with DEBOUNCE_CYCLES=4, FLASH_CYCLES=20.
// Stimulus pushes the cycle numbers at which key_press pulses, valid edges and
// flash_done pulses must appear; the monitor pops and compares on each event.
module tb_key_flash_ctrl;

  localparam int D  = 4;
  localparam int FC = 20;
`ifdef KEY_FLASH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic sys_clk;
  logic rst_n;
  logic key_in;
  logic valid;
  logic key_press;
  logic flash_done;

  key_flash_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .FLASH_CYCLES   (FC)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .valid     (valid),
    .key_press (key_press),
    .flash_done(flash_done)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // cyc = number of rising edges so far; read only at falling edges
  int cyc = 0;
  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  int q_press[$];
  int q_rise[$];
  int q_fall[$];
  int q_done[$];

  int checks = 0;
  int errors = 0;
  int idle_req = 0;
  int drain_req = 0;
  bit exp_hi = 1'b0;

  task automatic chk_val(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic ev_chk(input string nm, input int exp);
    checks++;
    if (exp < 0) begin
      errors++;
      $display("FAIL %s: event at cycle %0d, expected none", nm, cyc);
    end else if (exp != cyc) begin
      errors++;
      $display("FAIL %s: event at cycle %0d, expected cycle %0d", nm, cyc, exp);
    end
  endtask

  // Monitor: compares every observed event against the scoreboard.
  initial begin
    int idle_seen;
    int drain_seen;
    logic valid_q;
    idle_seen  = 0;
    drain_seen = 0;
    valid_q    = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (idle_req != idle_seen) begin
        idle_seen = idle_req;
        chk_val("reset_valid", int'(valid), 0);
        chk_val("reset_key_press", int'(key_press), 0);
        chk_val("reset_flash_done", int'(flash_done), 0);
      end
      if (drain_req != drain_seen) begin
        drain_seen = drain_req;
        chk_val("pending_key_press", q_press.size(), 0);
        chk_val("pending_valid_rise", q_rise.size(), 0);
        chk_val("pending_valid_fall", q_fall.size(), 0);
        chk_val("pending_flash_done", q_done.size(), 0);
        chk_val("level_valid", int'(valid), int'(exp_hi));
      end
      if (key_press === 1'b1) begin
        if (q_press.size() > 0) ev_chk("key_press", q_press.pop_front());
        else ev_chk("key_press", -1);
      end
      if (flash_done === 1'b1) begin
        if (q_done.size() > 0) ev_chk("flash_done", q_done.pop_front());
        else ev_chk("flash_done", -1);
      end
      if (valid === 1'b1 && valid_q === 1'b0) begin
        if (q_rise.size() > 0) ev_chk("valid_rise", q_rise.pop_front());
        else ev_chk("valid_rise", -1);
      end
      if (valid === 1'b0 && valid_q === 1'b1) begin
        if (q_fall.size() > 0) ev_chk("valid_fall", q_fall.pop_front());
        else ev_chk("valid_fall", -1);
      end
      valid_q = valid;
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge sys_clk);
  endtask

  task automatic drain();
    drain_req++;
    repeat (2) @(negedge sys_clk);
  endtask

  // Multi-cycle reset from a falling edge; outputs checked while held.
  task automatic do_reset();
    rst_n = 1'b0;
    if (exp_hi) q_fall.push_back(cyc + 1);
    exp_hi = 1'b0;
    @(negedge sys_clk);
    idle_req++;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  // Press sampled at E0 = edge n+1: pulse seen at cycle n+7, FSM acts at n+8.
  initial begin
    int n;
    int n2;
    key_in = 1'b1;
    rst_n  = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    idle_req++;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // Clean press held 10 cycles; then timeout (or stays on without the timer)
    n = cyc;
    q_press.push_back(n + 7);
    q_rise.push_back(n + 8);
    if (TO_EN) begin
      q_fall.push_back(n + 8 + FC);
      q_done.push_back(n + 8 + FC);
    end
    key_in = 1'b0;
    wait_until(n + 10);
    key_in = 1'b1;
    wait_until(n + 40);
    exp_hi = !TO_EN;
    drain();
    do_reset();

    // Bounce: low 3, high 1, low 3, high
    n = cyc;
    key_in = 1'b0;
    wait_until(n + 3);
    key_in = 1'b1;
    wait_until(n + 4);
    key_in = 1'b0;
    wait_until(n + 7);
    key_in = 1'b1;
    wait_until(n + 25);
    drain();

    // Toggle off: second press lands 10 cycles into FLASH
    n = cyc;
    q_press.push_back(n + 7);
    q_rise.push_back(n + 8);
    q_press.push_back(n + 17);
    q_fall.push_back(n + 18);
    key_in = 1'b0;
    wait_until(n + 4);
    key_in = 1'b1;
    wait_until(n + 10);
    key_in = 1'b0;
    wait_until(n + 20);
    key_in = 1'b1;
    wait_until(n + 45);
    drain();

    // Second press coincides with timer = FC-1
    n = cyc;
    q_press.push_back(n + 7);
    q_rise.push_back(n + 8);
    q_press.push_back(n + 27);
    q_fall.push_back(n + 28);
    if (TO_EN) q_done.push_back(n + 28);
    key_in = 1'b0;
    wait_until(n + 10);
    key_in = 1'b1;
    wait_until(n + 20);
    key_in = 1'b0;
    wait_until(n + 30);
    key_in = 1'b1;
    wait_until(n + 55);
    drain();

    // One-cycle reset at timer = 8, then a fresh press must time a full interval
    n = cyc;
    q_press.push_back(n + 7);
    q_rise.push_back(n + 8);
    key_in = 1'b0;
    wait_until(n + 10);
    key_in = 1'b1;
    wait_until(n + 16);
    rst_n = 1'b0;
    q_fall.push_back(n + 17);
    @(negedge sys_clk);
    rst_n = 1'b1;
    n2 = cyc;
    q_press.push_back(n2 + 7);
    q_rise.push_back(n2 + 8);
    if (TO_EN) begin
      q_fall.push_back(n2 + 8 + FC);
      q_done.push_back(n2 + 8 + FC);
    end
    key_in = 1'b0;
    wait_until(n2 + 10);
    key_in = 1'b1;
    wait_until(n2 + 40);
    exp_hi = !TO_EN;
    drain();
    do_reset();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
